// File: rtl/gemac_wb_regfile.sv
// Wishbone classic slave register file: settings registers, self-clearing command bits,
// live status, sticky events with mask and registered interrupt.
module gemac_wb_regfile #(
  parameter int                  AW       = 8,
  parameter int                  NREGS    = 8,
  parameter logic [NREGS*32-1:0] RST_VALS = '0,
  parameter int                  NEV      = 8,
  parameter int                  WAIT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic [AW-1:0]         wb_adr,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [NREGS*32-1:0]   settings_o,
  output logic [NREGS-1:0]      wr_pulse_o,
  output logic [7:0]            cmd_o,
  input  logic [7:0]            cmd_done_i,
  input  logic [31:0]           status_i,
  input  logic [NEV-1:0]        ev_i,
  output logic                  irq
);
  localparam logic [31:0] A_CMD  = 32'(NREGS);
  localparam logic [31:0] A_STAT = 32'(NREGS + 1);
  localparam logic [31:0] A_EV   = 32'(NREGS + 2);
  localparam logic [31:0] A_MASK = 32'(NREGS + 3);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

  state_t                  r_state, w_state_n;
  logic [1:0]              r_wcnt, w_wcnt_n;
  logic                    w_term;
  logic [NREGS-1:0][31:0]  r_set;
  logic [NREGS-1:0]        r_pulse;
  logic [7:0]              r_cmd;
  logic [NEV-1:0]          r_ev, r_mask, w_ev_clr;
  logic                    r_irq, r_ack, r_err;
  logic [31:0]             r_dat, w_rd, w_wa, w_lanes;
  logic                    w_req, w_bad, w_ack, w_wr;
  logic                    w_unused;

  assign w_req    = wb_cyc & wb_stb;
  assign w_wa     = 32'(wb_adr[AW-1:2]);
  assign w_lanes  = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
  assign w_bad    = (w_wa > A_MASK) | (wb_we & ((w_wa == A_STAT) | (wb_sel == 4'h0)));
  assign w_ack    = w_term & ~w_bad;
  assign w_wr     = w_ack & wb_we;
  assign w_ev_clr = (w_wr && w_wa == A_EV) ? (wb_dat_i[NEV-1:0] & w_lanes[NEV-1:0]) : '0;
  assign w_unused = &{1'b0, wb_adr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_wcnt  <= w_wcnt_n;
    end
  end

  // Termination is decided on the edge that registers ack/err, using the still-held bus inputs.
  always_comb begin
    w_state_n = r_state;
    w_wcnt_n  = r_wcnt;
    w_term    = 1'b0;
    case (r_state)
      S_IDLE: if (w_req) begin
        if (WAIT == 0) begin
          w_term    = 1'b1;
          w_state_n = S_TERM;
        end else begin
          w_wcnt_n  = 2'(WAIT - 1);
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req) w_state_n = S_IDLE;
        else if (r_wcnt == 2'd0) begin
          w_term    = 1'b1;
          w_state_n = S_TERM;
        end else w_wcnt_n = r_wcnt - 2'd1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NREGS; i++)
      if (w_wa == 32'(i)) w_rd = r_set[i];
    if (w_wa == A_CMD)  w_rd = 32'(r_cmd);
    if (w_wa == A_STAT) w_rd = status_i;
    if (w_wa == A_EV)   w_rd = 32'(r_ev);
    if (w_wa == A_MASK) w_rd = 32'(r_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_pulse <= '0;
      r_set   <= RST_VALS;
      r_cmd   <= '0;
      r_ev    <= '0;
      r_mask  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ack <= w_ack;
      r_err <= w_term & w_bad;
      r_dat <= (w_ack & ~wb_we) ? w_rd : '0;
      r_irq <= |(r_ev & r_mask);
      // A new event outranks a simultaneous clear of the same bit.
      r_ev  <= (r_ev & ~w_ev_clr) | ev_i;
      if (w_wr && w_wa == A_CMD && wb_sel[0]) r_cmd <= wb_dat_i[7:0];
      else                                    r_cmd <= r_cmd & ~cmd_done_i;
      if (w_wr && w_wa == A_MASK)
        r_mask <= (r_mask & ~w_lanes[NEV-1:0]) | (wb_dat_i[NEV-1:0] & w_lanes[NEV-1:0]);
      for (int i = 0; i < NREGS; i++) begin
        r_pulse[i] <= w_wr && (w_wa == 32'(i));
        if (w_wr && w_wa == 32'(i)) r_set[i] <= (r_set[i] & ~w_lanes) | (wb_dat_i & w_lanes);
      end
    end
  end

  assign wb_ack     = r_ack;
  assign wb_err     = r_err;
  assign wb_dat_o   = r_dat;
  assign settings_o = r_set;
  assign wr_pulse_o = r_pulse;
  assign cmd_o      = r_cmd;
  assign irq        = r_irq;

endmodule

// File: tb/tb_gemac_wb_regfile.sv
// Bench for gemac_wb_regfile: behavioural model tracks the WAIT=0 instance every cycle under
// random traffic; WAIT=2 and WAIT=3 instances get directed latency and abort checks.
module tb_gemac_wb_regfile;
  localparam int NR = 8;
  localparam logic [NR*32-1:0] RV0 = {32'hDEADBEEF, {5{32'h0}}, 32'h0, 32'h11111111};
  localparam logic [NR*32-1:0] RV1 = {{7{32'h0}}, 32'h0000003D};
  localparam logic [NR*32-1:0] RV2 = {{5{32'h0}}, 32'hA5A50002, 32'h0, 32'h0};

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] cyc = '0, stb = '0;
  logic we = 1'b0;
  logic [3:0] sel = '0;
  logic [7:0] adr = '0;
  logic [31:0] dat_i = '0, status = '0;
  logic [7:0] done = '0, ev = '0;

  logic [2:0] ack_w, err_w;
  logic [31:0] dat0, dat1, dat2;
  logic [NR*32-1:0] set0, set1, set2;
  logic [NR-1:0] pls0, pls1, pls2;
  logic [7:0] cmd0, cmd1, cmd2;
  logic irq0, irq1, irq2;

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  gemac_wb_regfile #(.RST_VALS(RV0), .WAIT(0)) u0 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we), .wb_sel(sel),
    .wb_adr(adr), .wb_dat_i(dat_i), .wb_dat_o(dat0), .wb_ack(ack_w[0]), .wb_err(err_w[0]),
    .settings_o(set0), .wr_pulse_o(pls0), .cmd_o(cmd0), .cmd_done_i(done),
    .status_i(status), .ev_i(ev), .irq(irq0));

  gemac_wb_regfile #(.RST_VALS(RV1), .WAIT(2)) u1 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we), .wb_sel(sel),
    .wb_adr(adr), .wb_dat_i(dat_i), .wb_dat_o(dat1), .wb_ack(ack_w[1]), .wb_err(err_w[1]),
    .settings_o(set1), .wr_pulse_o(pls1), .cmd_o(cmd1), .cmd_done_i(done),
    .status_i(status), .ev_i(ev), .irq(irq1));

  gemac_wb_regfile #(.RST_VALS(RV2), .WAIT(3)) u2 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_we(we), .wb_sel(sel),
    .wb_adr(adr), .wb_dat_i(dat_i), .wb_dat_o(dat2), .wb_ack(ack_w[2]), .wb_err(err_w[2]),
    .settings_o(set2), .wr_pulse_o(pls2), .cmd_o(cmd2), .cmd_done_i(done),
    .status_i(status), .ev_i(ev), .irq(irq2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat_of(input int u);
    case (u)
      0:       return dat0;
      1:       return dat1;
      default: return dat2;
    endcase
  endfunction

  // Starts at a negedge, holds the strobe until termination (bounded), returns at that negedge.
  task automatic xfer(input int u, input logic w, input int wa, input logic [3:0] s,
                      input logic [31:0] d, output int lat, output logic a, output logic e,
                      output logic [31:0] q);
    cyc[u] = 1'b1; stb[u] = 1'b1; we = w; adr = {6'(wa), 2'b00}; sel = s; dat_i = d;
    lat = 0; a = 1'b0; e = 1'b0; q = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack_w[u] || err_w[u]) begin
        lat = k; a = ack_w[u]; e = err_w[u]; q = dat_of(u);
        break;
      end
    end
    cyc[u] = 1'b0; stb[u] = 1'b0;
  endtask

  // Reference model of the WAIT=0 instance, stepped once per rising edge.
  logic [31:0] m_set [NR];
  logic [7:0]  m_cmd = '0, m_ev = '0, m_mask = '0;
  logic        m_irq = 1'b0, m_ack = 1'b0, m_err = 1'b0, m_rd = 1'b0;
  logic [31:0] m_dat = '0;
  logic [NR-1:0] m_pulse = '0;

  initial forever begin
    int wa;
    bit term, bad;
    logic [31:0] lm, rv;
    logic [7:0] clr, n_cmd;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) m_set[i] = RV0[32*i +: 32];
      m_cmd = '0; m_ev = '0; m_mask = '0; m_irq = 1'b0;
      m_ack = 1'b0; m_err = 1'b0; m_rd = 1'b0; m_dat = '0; m_pulse = '0;
    end else begin
      wa   = int'(adr[7:2]);
      term = cyc[0] && stb[0] && !m_ack && !m_err;
      bad  = (wa > NR + 3) || (we && (wa == NR + 1 || sel == 4'h0));
      lm   = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      if (wa < NR)           rv = m_set[wa];
      else if (wa == NR)     rv = {24'h0, m_cmd};
      else if (wa == NR + 1) rv = status;
      else if (wa == NR + 2) rv = {24'h0, m_ev};
      else if (wa == NR + 3) rv = {24'h0, m_mask};
      else                   rv = '0;
      m_irq   = |(m_ev & m_mask);
      clr     = '0;
      n_cmd   = m_cmd & ~done;
      m_pulse = '0;
      if (term && !bad && we) begin
        if (wa < NR) begin
          m_set[wa]   = (m_set[wa] & ~lm) | (dat_i & lm);
          m_pulse[wa] = 1'b1;
        end else if (wa == NR && sel[0]) n_cmd = dat_i[7:0];
        else if (wa == NR + 2) clr = dat_i[7:0] & lm[7:0];
        else if (wa == NR + 3) m_mask = (m_mask & ~lm[7:0]) | (dat_i[7:0] & lm[7:0]);
      end
      m_cmd = n_cmd;
      m_ev  = (m_ev & ~clr) | ev;
      m_ack = term && !bad;
      m_err = term && bad;
      m_rd  = term && !bad && !we;
      m_dat = m_rd ? rv : '0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("ack", 32'(ack_w[0]), 32'(m_ack));
    chk("err", 32'(err_w[0]), 32'(m_err));
    chk("irq", 32'(irq0), 32'(m_irq));
    chk("cmd_o", 32'(cmd0), 32'(m_cmd));
    chk("wr_pulse", 32'(pls0), 32'(m_pulse));
    for (int i = 0; i < NR; i++) chk("settings", set0[32*i +: 32], m_set[i]);
    if (m_rd || m_err) chk("dat_o", dat0, m_dat);
  end

  initial begin
    int lat, wa;
    logic a, e, seen;
    logic [31:0] q;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ack", 32'(ack_w), 32'h0);
    chk("rst_err", 32'(err_w), 32'h0);
    chk("rst_dat", dat0, 32'h0);
    chk("rst_irq", 32'(irq0), 32'h0);
    chk("rst_set0_r0", set0[31:0], 32'h11111111);
    chk("rst_set1_r0", set1[31:0], 32'h0000003D);
    rst = 1'b0;

    // Byte-lane write, WAIT=0
    xfer(0, 1'b1, 1, 4'b0101, 32'h12345678, lat, a, e, q);
    chk("w0_lat", 32'(lat), 32'd1);
    chk("w0_ack", 32'(a), 32'd1);
    chk("w0_reg1", set0[63:32], 32'h00340078);
    chk("w0_pulse", 32'(pls0), 32'h02);
    @(negedge clk);
    chk("w0_pulse_end", 32'(pls0), 32'h0);
    chk("w0_ack_end", 32'(ack_w[0]), 32'h0);

    // Command bits
    xfer(0, 1'b1, NR, 4'h1, 32'h06, lat, a, e, q);
    chk("cmd_load", 32'(cmd0), 32'h06);
    done = 8'h04; @(negedge clk); done = 8'h00;
    chk("cmd_done", 32'(cmd0), 32'h02);
    done = 8'h04;
    xfer(0, 1'b1, NR, 4'h1, 32'h04, lat, a, e, q);
    done = 8'h00;
    chk("cmd_win", 32'(cmd0), 32'h04);

    // Events, mask, irq
    xfer(0, 1'b1, NR + 3, 4'hF, 32'h01, lat, a, e, q);
    ev = 8'h03; @(negedge clk); ev = 8'h00;
    chk("irq_lag", 32'(irq0), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq0), 32'h1);
    xfer(0, 1'b0, NR + 2, 4'hF, 32'h0, lat, a, e, q);
    chk("ev_read", q, 32'h03);
    xfer(0, 1'b1, NR + 2, 4'hF, 32'h01, lat, a, e, q);
    @(negedge clk);
    chk("irq_clr", 32'(irq0), 32'h0);
    xfer(0, 1'b0, NR + 2, 4'hF, 32'h0, lat, a, e, q);
    chk("ev_w1c", q, 32'h02);
    ev = 8'h02;
    xfer(0, 1'b1, NR + 2, 4'hF, 32'h02, lat, a, e, q);
    ev = 8'h00;
    xfer(0, 1'b0, NR + 2, 4'hF, 32'h0, lat, a, e, q);
    chk("ev_set_wins", q, 32'h02);

    // Error terminations
    xfer(0, 1'b0, NR + 4, 4'hF, 32'h0, lat, a, e, q);
    chk("unmap_err", 32'({a, e}), 32'b01);
    chk("unmap_dat", q, 32'h0);
    @(negedge clk);
    chk("err_single", 32'(err_w[0]), 32'h0);
    status = 32'hCAFEF00D;
    xfer(0, 1'b1, NR + 1, 4'hF, 32'h1, lat, a, e, q);
    chk("stat_wr_err", 32'({a, e}), 32'b01);
    xfer(0, 1'b0, NR + 1, 4'hF, 32'h0, lat, a, e, q);
    chk("stat_rd", q, 32'hCAFEF00D);
    xfer(0, 1'b1, 2, 4'h0, 32'hFFFFFFFF, lat, a, e, q);
    chk("sel0_err", 32'({a, e}), 32'b01);
    chk("sel0_pulse", 32'(pls0), 32'h0);
    chk("sel0_reg2", set0[95:64], 32'h0);

    // WAIT=2 read latency
    xfer(1, 1'b0, 0, 4'hF, 32'h0, lat, a, e, q);
    chk("w2_lat", 32'(lat), 32'd3);
    chk("w2_dat", q, 32'h0000003D);
    @(negedge clk);
    chk("w2_ack_end", 32'(ack_w[1]), 32'h0);

    // WAIT=3 aborts: strobe drop, then reset mid-access, then retry
    cyc[2] = 1'b1; stb[2] = 1'b1; we = 1'b1; adr = {6'd2, 2'b00}; sel = 4'hF; dat_i = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    stb[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= ack_w[2] | err_w[2]; end
    cyc[2] = 1'b0;
    chk("drop_noterm", 32'(seen), 32'h0);
    chk("drop_reg2", set2[95:64], 32'hA5A50002);
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= ack_w[2] | err_w[2]; end
    chk("rst_noterm", 32'(seen), 32'h0);
    chk("rst_reg2", set2[95:64], 32'hA5A50002);
    xfer(2, 1'b1, 2, 4'hF, 32'hFFFFFFFF, lat, a, e, q);
    chk("w3_lat", 32'(lat), 32'd4);
    chk("w3_reg2", set2[95:64], 32'hFFFFFFFF);

    // Random traffic on the WAIT=0 instance
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      cyc[0] = ($urandom_range(0, 3) != 0);
      stb[0] = cyc[0] && ($urandom_range(0, 3) != 0);
      we     = 1'($urandom_range(0, 1));
      wa     = int'($urandom_range(0, 13));
      adr    = {6'(wa), 2'($urandom)};
      sel    = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      dat_i  = $urandom;
      status = $urandom;
      ev     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      done   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      @(negedge clk);
    end
    rst = 1'b0; cyc = '0; stb = '0; ev = '0; done = '0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gemac_wb_regfile.md
GEMAC_WB_REGFILE -- requirements
Module: gemac_wb_regfile

Interface
REQ-001 Parameter AW, default 8: Wishbone byte-address width; the word address is wb_adr[AW-1:2].
REQ-002 Parameter NREGS, default 8: number of 32-bit read/write settings registers, legal range 1..32.
REQ-003 Parameter RST_VALS, default all zeros: NREGS*32-bit vector; register i resets to RST_VALS[32*i+31:32*i].
REQ-004 Parameter NEV, default 8: number of sticky event bits, legal range 1..32.
REQ-005 Parameter WAIT, default 0: extra ack wait states, legal range 0..3.
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wb_cyc, wb_stb, wb_we  in  1 each  Wishbone classic cycle, strobe and write enable.
REQ-009 wb_sel  in  4  byte-lane write enables.
REQ-010 wb_adr  in  AW  byte address.
REQ-011 wb_dat_i  in  32  write data.
REQ-012 wb_dat_o  out  32  read data, registered, valid while wb_ack=1.
REQ-013 wb_ack, wb_err  out  1 each  single-cycle termination pulses.
REQ-014 settings_o  out  NREGS*32  current values of the settings registers, flattened.
REQ-015 wr_pulse_o  out  NREGS  one-cycle pulse per settings register on the cycle it is written.
REQ-016 cmd_o  out  8  self-clearing command bits.
REQ-017 cmd_done_i  in  8  per-bit completion pulses.
REQ-018 status_i  in  32  read-only live status.
REQ-019 ev_i  in  NEV  event pulses.
REQ-020 irq  out  1  registered interrupt.

Function
REQ-021 The word-address map SHALL be: 0..NREGS-1 settings; NREGS CMD; NREGS+1 STATUS (read-only); NREGS+2 EVENT (write-1-to-clear); NREGS+3 EVMASK; any higher address is unmapped.
REQ-022 An access SHALL start on a cycle with wb_cyc & wb_stb = 1 while no termination is pending or being driven.
REQ-023 The block SHALL assert exactly one termination pulse exactly 1+WAIT cycles after the access starts.
REQ-024 With WAIT=0, back-to-back strobes SHALL terminate every other cycle.
REQ-025 Termination SHALL be wb_err for unmapped addresses, for writes to STATUS, and for any write with wb_sel=0; it SHALL be wb_ack otherwise.
REQ-026 If wb_cyc or wb_stb drops before termination, the access SHALL abort with no termination and no side effects.
REQ-027 Writes SHALL update state on the same clock edge that raises wb_ack; an errored write SHALL change no state.
REQ-028 Settings and EVMASK writes SHALL update only the byte lanes enabled by wb_sel.
REQ-029 A settings write SHALL pulse wr_pulse_o[i] for that edge's cycle only.
REQ-030 A CMD write SHALL load cmd_o from wb_dat_i[7:0] when wb_sel[0]=1.
REQ-031 cmd_o[k] SHALL clear on cmd_done_i[k].
REQ-032 When a CMD write and cmd_done_i[k] occur together, the write SHALL win.
REQ-033 Each event bit SHALL set when ev_i[k]=1.
REQ-034 An EVENT write SHALL clear the event bits written as 1 (lane-gated).
REQ-035 When an event set and a clear occur together, the set SHALL win.
REQ-036 irq SHALL be registered as |(EVENT & EVMASK), lagging the EVENT register by one cycle.
REQ-037 Reads SHALL have no side effects.
REQ-038 Bits above width in CMD, EVENT and EVMASK SHALL read as 0.
REQ-039 wb_dat_o SHALL read 0 on error terminations.

Reset
REQ-040 On rst, every output SHALL clear: wb_ack, wb_err, wb_dat_o, wr_pulse_o, cmd_o, irq = 0.
REQ-041 On rst, settings SHALL load RST_VALS, and EVENT and EVMASK SHALL clear to 0.
REQ-042 rst during an access SHALL abort it with no termination; the master retries the access.

Verification
REQ-043 WAIT=0: write 0x12345678 to reg 1 with sel=4'b0101 over reset value 0 -> ack on cycle T+1, settings reg 1 = 0x00340078, wr_pulse_o[1] high for 1 cycle.
REQ-044 WAIT=2: read reg 0 with RST_VALS reg 0 = 0x0000003D -> ack on cycle T+3 only, wb_dat_o = 0x3D.
REQ-045 Write CMD=0x06 -> cmd_o=0x06; pulse cmd_done_i=0x04 -> cmd_o=0x02; a CMD write of 0x04 coinciding with done=0x04 -> cmd_o=0x04.
REQ-046 EVMASK=0x01, pulse ev_i=0x03 -> EVENT=0x03 and irq=1 one cycle later; write EVENT=0x01 -> EVENT=0x02, irq=0; an ev_i[1] pulse and a write EVENT=0x02 on the same cycle -> bit 1 stays 1.
REQ-047 Access word address NREGS+4, write STATUS, or write with sel=0 -> wb_err single pulse, no ack, no state change.
REQ-048 Drop wb_stb mid-wait (WAIT=3), or assert rst mid-access -> no ack/err, target register unchanged.
